// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: table-driven power-up configuration of an I2C slave.
// Walks a sync ROM, drives i2c_control, retries, delays, reports done/error.
module i2c_init_sequencer #(
   parameter int         TBL_AW     = 8,
   parameter logic [7:0] DEVICE_ID  = 8'h78,
   parameter logic       ADDR_MODE  = 1'b1,
   parameter int         MAX_RETRY  = 3,
   parameter int         DELAY_UNIT = 50000
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [TBL_AW-1:0] err_index,
   output logic [TBL_AW-1:0] tbl_addr,
   input  logic [25:0]       tbl_data,
   output logic              wrreg_req,
   output logic              rdreg_req,
   output logic [15:0]       addr,
   output logic              addr_mode,
   output logic [7:0]        wrdata,
   output logic [7:0]        device_id,
   input  logic [7:0]        rddata,
   input  logic              RW_Done,
   input  logic              ack
);

   localparam int CNT_W = $clog2(255 * DELAY_UNIT + 1);
   localparam int RTY_W = $clog2(MAX_RETRY + 2);
   localparam logic [TBL_AW-1:0] LAST = '1;

   localparam logic [1:0] OP_WR  = 2'b00;
   localparam logic [1:0] OP_DLY = 2'b01;
   localparam logic [1:0] OP_VF  = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT,
      S_GAP, S_DLY, S_ADV, S_DONE, S_ERR
   } state_t;

   state_t             state_q, state_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic [TBL_AW-1:0]  err_index_q, err_index_d;
   logic [TBL_AW-1:0]  tbl_addr_q, tbl_addr_d;
   logic               wrreg_q, wrreg_d;
   logic               rdreg_q, rdreg_d;
   logic [15:0]        addr_q, addr_d;
   logic [7:0]         wrdata_q, wrdata_d;
   logic [1:0]         op_q, op_d;
   logic [RTY_W-1:0]   retry_q, retry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   dly_cycles;
   logic               fail;

   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign err_index = err_index_q;
   assign tbl_addr  = tbl_addr_q;
   assign wrreg_req = wrreg_q;
   assign rdreg_req = rdreg_q;
   assign addr      = addr_q;
   assign wrdata    = wrdata_q;
   assign addr_mode = ADDR_MODE;
   assign device_id = DEVICE_ID;

   assign dly_cycles = CNT_W'(tbl_data[7:0]) * CNT_W'(DELAY_UNIT);
   // wrdata_q doubles as the expected readback value for VERIFY entries
   assign fail = ack | ((op_q == OP_VF) & (rddata != wrdata_q));

   // next-state and registered-output computation for the sequencer
   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
      err_index_d = err_index_q;
      tbl_addr_d  = tbl_addr_q;
      wrreg_d     = 1'b0;
      rdreg_d     = 1'b0;
      addr_d      = addr_q;
      wrdata_d    = wrdata_q;
      op_d        = op_q;
      retry_d     = retry_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_FETCH;
               busy_d      = 1'b1;
               error_d     = 1'b0;
               err_index_d = '0;
               tbl_addr_d  = '0;
               retry_d     = '0;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            op_d = tbl_data[25:24];
            unique case (tbl_data[25:24])
               OP_WR, OP_VF: begin
                  state_d  = S_ISSUE;
                  addr_d   = tbl_data[23:8];
                  wrdata_d = tbl_data[7:0];
                  wrreg_d  = (tbl_data[25:24] == OP_WR);
                  rdreg_d  = (tbl_data[25:24] == OP_VF);
               end
               OP_DLY: begin
                  if (tbl_data[7:0] == 8'd0) begin
                     state_d = S_ADV;
                  end else begin
                     state_d = S_DLY;
                     cnt_d   = dly_cycles - CNT_W'(1);
                  end
               end
               default: begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end
            endcase
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (RW_Done) begin
               if (!fail) begin
                  state_d = S_ADV;
               end else if (retry_q != RTY_W'(MAX_RETRY)) begin
                  retry_d = retry_q + RTY_W'(1);
                  state_d = S_GAP;
               end else begin
                  state_d     = S_ERR;
                  error_d     = 1'b1;
                  err_index_d = tbl_addr_q;
                  busy_d      = 1'b0;
               end
            end
         end
         S_GAP: begin
            state_d = S_ISSUE;
            wrreg_d = (op_q == OP_WR);
            rdreg_d = (op_q == OP_VF);
         end
         S_DLY: begin
            if (cnt_q == '0) state_d = S_ADV;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_ADV: begin
            retry_d = '0;
            if (tbl_addr_q == LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               tbl_addr_d = tbl_addr_q + TBL_AW'(1);
               state_d    = S_FETCH;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // state and output registers, cleared asynchronously
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_index_q <= '0;
         tbl_addr_q  <= '0;
         wrreg_q     <= 1'b0;
         rdreg_q     <= 1'b0;
         addr_q      <= '0;
         wrdata_q    <= '0;
         op_q        <= '0;
         retry_q     <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_index_q <= err_index_d;
         tbl_addr_q  <= tbl_addr_d;
         wrreg_q     <= wrreg_d;
         rdreg_q     <= rdreg_d;
         addr_q      <= addr_d;
         wrdata_q    <= wrdata_d;
         op_q        <= op_d;
         retry_q     <= retry_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer: timeline model of the sequencer, per-cycle compare,
// sync ROM and scripted i2c_control responder.
module tb_i2c_init_sequencer;

   localparam int AW   = 2;
   localparam int NENT = 4;
   localparam int DU   = 10;
   localparam int MAXR = 3;
   localparam int L    = 3;
   localparam int MAXC = 128;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, error;
   logic [1:0]  err_index, tbl_addr;
   logic [25:0] tbl_data = '0;
   logic        wrreg_req, rdreg_req;
   logic [15:0] addr;
   logic        addr_mode;
   logic [7:0]  wrdata, device_id;
   logic [7:0]  rddata = '0;
   logic        RW_Done = 1'b0;
   logic        ack = 1'b0;

   i2c_init_sequencer #(
      .TBL_AW(AW), .DEVICE_ID(8'h78), .ADDR_MODE(1'b1),
      .MAX_RETRY(MAXR), .DELAY_UNIT(DU)
   ) dut (
      .Clk(clk), .Rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .error(error), .err_index(err_index), .tbl_addr(tbl_addr),
      .tbl_data(tbl_data), .wrreg_req(wrreg_req), .rdreg_req(rdreg_req),
      .addr(addr), .addr_mode(addr_mode), .wrdata(wrdata),
      .device_id(device_id), .rddata(rddata), .RW_Done(RW_Done), .ack(ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int s_cyc = 0;
   bit chk_en = 0;
   string tname = "";

   logic [25:0] rom [NENT];
   bit          r_ack [16];
   logic [7:0]  r_rd [16];
   int          slave_k = 0;

   bit          eb [MAXC];
   bit          ed [MAXC];
   bit          ee [MAXC];
   bit          ew [MAXC];
   bit          er [MAXC];
   logic [1:0]  ei [MAXC];
   logic [1:0]  eta [MAXC];
   logic [15:0] ea [MAXC];
   logic [7:0]  ewd [MAXC];

   int          req_idx [$];
   logic [15:0] req_addr [$];
   logic [7:0]  req_wd [$];
   bit          req_rd [$];
   int          done_idx = -1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) tbl_data <= rom[tbl_addr];

   // i2c_control stand-in: RW_Done L cycles after each request
   int  s_rem = 0;
   bit  s_pend = 0;
   always @(negedge clk) begin
      RW_Done = 1'b0;
      ack = 1'b0;
      if (!rst_n) begin
         s_pend = 0;
      end else begin
         if (s_pend) begin
            s_rem--;
            if (s_rem == 0) begin
               s_pend = 0;
               RW_Done = 1'b1;
               ack = (slave_k < 16) ? r_ack[slave_k] : 1'b0;
               rddata = (slave_k < 16) ? r_rd[slave_k] : 8'h00;
               slave_k++;
            end
         end
         if (wrreg_req || rdreg_req) begin
            s_pend = 1;
            s_rem = L;
         end
      end
   end

   // per-cycle comparison against the model timeline
   always @(negedge clk) begin
      int idx;
      if (chk_en) begin
         idx = cyc - s_cyc;
         if (idx >= 1 && idx < MAXC) begin
            checks++;
            if (busy !== eb[idx] || done !== ed[idx] || error !== ee[idx] ||
                err_index !== ei[idx] || wrreg_req !== ew[idx] ||
                rdreg_req !== er[idx] || tbl_addr !== eta[idx] ||
                addr_mode !== 1'b1 || device_id !== 8'h78 ||
                ((ew[idx] || er[idx]) && addr !== ea[idx]) ||
                (ew[idx] && wrdata !== ewd[idx])) begin
               failures++;
               $display("FAIL %s cyc%0d busy=%b/%b done=%b/%b err=%b/%b eidx=%0d/%0d wr=%b/%b rd=%b/%b ta=%0d/%0d addr=%h/%h wd=%h/%h",
                  tname, idx, busy, eb[idx], done, ed[idx], error, ee[idx],
                  err_index, ei[idx], wrreg_req, ew[idx], rdreg_req, er[idx],
                  tbl_addr, eta[idx], addr, ea[idx], wrdata, ewd[idx]);
            end
            if (wrreg_req || rdreg_req) begin
               req_idx.push_back(idx);
               req_addr.push_back(addr);
               req_wd.push_back(wrdata);
               req_rd.push_back(rdreg_req);
            end
            if (done) done_idx = idx;
         end
      end
   end

   // expected timeline derived from the table and the response script
   task automatic build_model(output int fin);
      int c, i, r, d, att, rq, adv;
      bit stop, adv_ok, resolved, fail;
      logic [1:0]  op;
      logic [15:0] a;
      logic [7:0]  v;
      for (int k = 0; k < MAXC; k++) begin
         eb[k] = 0; ed[k] = 0; ee[k] = 0; ew[k] = 0; er[k] = 0;
         ei[k] = '0; eta[k] = '0; ea[k] = '0; ewd[k] = '0;
      end
      c = 1; i = 0; rq = 0; fin = 0; stop = 0;
      while (!stop) begin
         for (int k = c; k < MAXC; k++) eta[k] = 2'(i);
         op = rom[i][25:24];
         a  = rom[i][23:8];
         v  = rom[i][7:0];
         adv = 0; adv_ok = 0;
         if (op == 2'b11) begin
            fin = c + 2; ed[fin] = 1; stop = 1;
         end else if (op == 2'b01) begin
            adv = c + 2 + int'(v) * DU; adv_ok = 1;
         end else begin
            r = c + 2; att = 0; resolved = 0;
            while (!resolved) begin
               ew[r] = (op == 2'b00);
               er[r] = (op == 2'b10);
               ea[r] = a;
               ewd[r] = v;
               d = r + L;
               fail = r_ack[rq] || (op == 2'b10 && r_rd[rq] != v);
               rq++;
               if (!fail) begin
                  adv = d + 1; adv_ok = 1; resolved = 1;
               end else if (att < MAXR) begin
                  att++; r = d + 2;
               end else begin
                  fin = d + 1; stop = 1; resolved = 1;
                  for (int k = fin; k < MAXC; k++) begin
                     ee[k] = 1; ei[k] = 2'(i);
                  end
               end
            end
         end
         if (adv_ok) begin
            if (i == NENT - 1) begin
               fin = adv + 1; ed[fin] = 1; stop = 1;
            end else begin
               c = adv + 1; i++;
            end
         end
      end
      for (int k = 1; k < fin; k++) eb[k] = 1;
   endtask

   task automatic run_test(input string nm, input int x1, input int x2);
      int fin;
      tname = nm;
      build_model(fin);
      slave_k = 0;
      req_idx.delete(); req_addr.delete(); req_wd.delete(); req_rd.delete();
      done_idx = -1;
      @(negedge clk);
      start = 1'b1;
      s_cyc = cyc;
      chk_en = 1;
      for (int k = 1; k <= fin + 4; k++) begin
         @(negedge clk);
         start = (k == x1) || (k == x2);
      end
      @(negedge clk);
      start = 1'b0;
      chk_en = 0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_done"}, 32'(done), 0);
      chk({nm, "_err"}, 32'(error), 0);
      chk({nm, "_eidx"}, 32'(err_index), 0);
      chk({nm, "_ta"}, 32'(tbl_addr), 0);
      chk({nm, "_req"}, {30'd0, wrreg_req, rdreg_req}, 0);
      chk({nm, "_addr"}, 32'(addr), 0);
      chk({nm, "_wd"}, 32'(wrdata), 0);
   endtask

   function automatic int qi(input int k);
      return (k < req_idx.size()) ? req_idx[k] : -1;
   endfunction

   function automatic logic [23:0] qaw(input int k);
      return (k < req_idx.size()) ? {req_addr[k], req_wd[k]} : 24'hFFFFFF;
   endfunction

   function automatic logic [25:0] ent(input logic [1:0] op, input logic [15:0] a,
                                       input logic [7:0] v);
      return {op, a, v};
   endfunction

   task automatic clear_script();
      for (int k = 0; k < 16; k++) begin
         r_ack[k] = 0; r_rd[k] = 8'h00;
      end
   endtask

   initial begin
      int n;
      for (int k = 0; k < NENT; k++) rom[k] = ent(2'b11, 16'h0, 8'h0);
      clear_script();
      #1;
      chk_reset("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      rom[0] = ent(2'b00, 16'h3008, 8'h82);
      rom[1] = ent(2'b00, 16'h3103, 8'h03);
      rom[2] = ent(2'b11, 16'h0, 8'h0);
      run_test("t1", -1, -1);
      chk("t1_nreq", req_idx.size(), 2);
      chk("t1_req0_cyc", qi(0), 3);
      chk("t1_req0", qaw(0), 24'h300882);
      chk("t1_req1_cyc", qi(1), 10);
      chk("t1_req1", qaw(1), 24'h310303);
      chk("t1_done_cyc", done_idx, 17);
      chk("t1_err", 32'(error), 0);

      clear_script();
      for (int k = 1; k <= 4; k++) r_ack[k] = 1;
      run_test("t2", -1, -1);
      n = 0;
      for (int k = 0; k < req_idx.size(); k++)
         if (req_addr[k] == 16'h3103) n++;
      chk("t2_retries", n, 4);
      chk("t2_err", 32'(error), 1);
      chk("t2_eidx", 32'(err_index), 1);
      chk("t2_nodone", done_idx, -1);
      chk("t2_busy", 32'(busy), 0);

      rst_n = 1'b0;
      #1;
      chk_reset("rst_err");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      clear_script();
      r_rd[0] = 8'h55;
      r_rd[1] = 8'h56;
      rom[0] = ent(2'b10, 16'h300A, 8'h56);
      rom[1] = ent(2'b11, 16'h0, 8'h0);
      run_test("t3", -1, -1);
      chk("t3_nreq", req_idx.size(), 2);
      chk("t3_rd", {30'd0, req_rd.size() > 1 && req_rd[1], req_rd.size() > 0 && req_rd[0]}, 3);
      chk("t3_req1_cyc", qi(1), 8);
      chk("t3_done_cyc", done_idx, 15);

      clear_script();
      rom[0] = ent(2'b01, 16'h0, 8'd3);
      rom[1] = ent(2'b00, 16'h4000, 8'hA5);
      rom[2] = ent(2'b01, 16'h0, 8'd0);
      rom[3] = ent(2'b00, 16'h4001, 8'h5A);
      run_test("t4", -1, -1);
      chk("t4_req0_cyc", qi(0), 36);
      chk("t4_req1_cyc", qi(1), 46);
      chk("t4_done_cyc", done_idx, 51);

      clear_script();
      rom[0] = ent(2'b00, 16'h3008, 8'h82);
      rom[1] = ent(2'b00, 16'h3103, 8'h03);
      rom[2] = ent(2'b11, 16'h0, 8'h0);
      run_test("t5_ign", 5, 17);
      chk("t5_done_cyc", done_idx, 17);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_busy_pre", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk_reset("t5_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk_reset("t5_post");

      clear_script();
      rom[0] = ent(2'b00, 16'h0010, 8'h01);
      rom[1] = ent(2'b00, 16'h0011, 8'h02);
      rom[2] = ent(2'b00, 16'h0012, 8'h03);
      rom[3] = ent(2'b00, 16'h0013, 8'h04);
      run_test("t6", -1, -1);
      chk("t6_nreq", req_idx.size(), 4);
      chk("t6_req3_cyc", qi(3), 24);
      chk("t6_req3", qaw(3), 24'h001304);
      chk("t6_done_cyc", done_idx, 29);
      chk("t6_ta", 32'(tbl_addr), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
